regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_if.sv | 26 ++
 rtl/regfile_rd_mux.sv | 29 ++
 rtl/regfile_mp.sv | 79 +++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: default widths and the port-1-priority write select shared by regfile_mp.
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    typedef enum logic [1:0] {SEL_NONE, SEL_P0, SEL_P1} wsel_e;

    function automatic wsel_e wr_sel(input logic hit0, input logic hit1);
        return hit1 ? SEL_P1 : (hit0 ? SEL_P0 : SEL_NONE);
    endfunction
endpackage

// File: rtl/regfile_if.sv
// regfile_if: two write ports, packed read ports and the collision flag of regfile_mp.
interface regfile_if import regfile_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = DEF_NUM_RD
);
    logic                     WrEn0;
    logic [ADDR_W-1:0]        Aw0;
    logic [DATA_W-1:0]        Dw0;
    logic                     WrEn1;
    logic [ADDR_W-1:0]        Aw1;
    logic [DATA_W-1:0]        Dw1;
    logic [NUM_RD*ADDR_W-1:0] Ar;
    logic [NUM_RD*DATA_W-1:0] Dr;
    logic [NUM_RD-1:0]        Vr;
    logic                     wr_collide;

    modport master (
        output WrEn0, Aw0, Dw0, WrEn1, Aw1, Dw1, Ar,
        input  Dr, Vr, wr_collide
    );
    modport slave (
        input  WrEn0, Aw0, Dw0, WrEn1, Aw1, Dw1, Ar,
        output Dr, Vr, wr_collide
    );
endinterface

// File: rtl/regfile_rd_mux.sv
// regfile_rd_mux: one combinational read port with optional same-cycle write forwarding.
module regfile_rd_mux import regfile_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic [ADDR_W-1:0]                   ar_i,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]    mem_i,
    input  logic [2**ADDR_W-1:0]                vld_i,
    input  logic                                rst_i,
    input  logic                                byp0_i,
    input  logic [ADDR_W-1:0]                   aw0_i,
    input  logic [DATA_W-1:0]                   dw0_i,
    input  logic                                byp1_i,
    input  logic [ADDR_W-1:0]                   aw1_i,
    input  logic [DATA_W-1:0]                   dw1_i,
    output logic [DATA_W-1:0]                   dr_o,
    output logic                                vr_o
);
    logic  zero;
    wsel_e sel;

    assign zero = (ZERO_REG != 0) && (ar_i == '0);
    assign sel  = zero ? SEL_NONE : wr_sel(byp0_i && aw0_i == ar_i, byp1_i && aw1_i == ar_i);
    assign dr_o = (rst_i || zero) ? '0 :
                  (sel == SEL_P1) ? dw1_i :
                  (sel == SEL_P0) ? dw0_i : mem_i[ar_i];
    assign vr_o = zero || (sel != SEL_NONE) || vld_i[ar_i];
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 2-write / NUM_RD-read register file with per-register valid bits and collision flag.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp import regfile_pkg::*; #(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic     clk,
    input  logic     reset,
    regfile_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]             vld_q, vld_d;
    logic                         col_q, col_d;
    logic                         byp0, byp1;

    // Register 0 is skipped entirely when hardwired, so its valid bit never sets.
    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        for (int i = (ZERO_REG != 0) ? 1 : 0; i < DEPTH; i++) begin
            case (wr_sel(bus.WrEn0 && bus.Aw0 == ADDR_W'(i), bus.WrEn1 && bus.Aw1 == ADDR_W'(i)))
                SEL_P0: begin
                    mem_d[i] = bus.Dw0;
                    vld_d[i] = 1'b1;
                end
                SEL_P1: begin
                    mem_d[i] = bus.Dw1;
                    vld_d[i] = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign col_d = bus.WrEn0 && bus.WrEn1 && (bus.Aw0 == bus.Aw1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '0;
            vld_q <= '0;
            col_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            vld_q <= vld_d;
            col_q <= col_d;
        end
    end

    assign bus.wr_collide = col_q;

`ifdef REGFILE_BYPASS_EN
    assign byp0 = bus.WrEn0 && !reset;
    assign byp1 = bus.WrEn1 && !reset;
`else
    assign byp0 = 1'b0;
    assign byp1 = 1'b0;
`endif

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        regfile_rd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_rd (
            .ar_i   (bus.Ar[g*ADDR_W +: ADDR_W]),
            .mem_i  (mem_q),
            .vld_i  (vld_q),
            .rst_i  (reset),
            .byp0_i (byp0),
            .aw0_i  (bus.Aw0),
            .dw0_i  (bus.Dw0),
            .byp1_i (byp1),
            .aw1_i  (bus.Aw1),
            .dw1_i  (bus.Dw1),
            .dr_o   (bus.Dr[g*DATA_W +: DATA_W]),
            .vr_o   (bus.Vr[g])
        );
    end
endmodule
